// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution bank router.
// Holds the state encoding, bank-count derivation and pointer wrap helper.
package conv_pkg;

    localparam int unsigned BITS_IMAGEN_DEF = 8;
    localparam int unsigned BITS_DATA_DEF   = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_READOUT
    } state_t;

    function automatic int unsigned nbank(input int unsigned n, input int unsigned m_len);
        return n + m_len - 1;
    endfunction

    // Wrap a + b into [0, m); callers guarantee a < m and b <= m.
    function automatic int unsigned mod_add(input int unsigned a, input int unsigned b,
                                            input int unsigned m);
        int unsigned s;
        s = a + b;
        if (s >= m) s = s - m;
        return s;
    endfunction

endpackage

// File: rtl/bank_window_mux.sv
// Registered rotation mux: NBANK bank pixels -> N lanes x M_LEN rows,
// row j of lane k taken from bank (base + k + j) mod NBANK.
module bank_window_mux
    import conv_pkg::*;
#(
    parameter int unsigned N           = 2,
    parameter int unsigned M_LEN       = 3,
    parameter int unsigned BITS_IMAGEN = BITS_IMAGEN_DEF,
    parameter int unsigned NBANK       = 4,
    parameter int unsigned BW          = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [BW-1:0]                     base,
    input  logic [NBANK*BITS_IMAGEN-1:0]      mem_pix,
    output logic [N*M_LEN*BITS_IMAGEN-1:0]    win_data,
    output logic                              win_valid
);

    logic [BITS_IMAGEN-1:0]           pix     [NBANK];
    logic [BITS_IMAGEN-1:0]           win_arr [N*M_LEN];
    logic [N*M_LEN*BITS_IMAGEN-1:0]   win_nxt;

    for (genvar b = 0; b < NBANK; b++) begin : g_pix
        assign pix[b] = mem_pix[b*BITS_IMAGEN +: BITS_IMAGEN];
    end

    for (genvar w = 0; w < N*M_LEN; w++) begin : g_win
        assign win_nxt[w*BITS_IMAGEN +: BITS_IMAGEN] = win_arr[w];
    end

    always_comb begin
        logic [BW-1:0] bank;
        bank = '0;
        for (int unsigned w = 0; w < N*M_LEN; w++) win_arr[w] = '0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned j = 0; j < M_LEN; j++) begin
                bank = BW'(mod_add(32'(base), k + j, NBANK));
                win_arr[k*M_LEN + j] = pix[bank];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_data  <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= in_valid;
            if (in_valid) win_data <= win_nxt;
        end
    end

endmodule

// File: rtl/conv_bank_router.sv
// Bank load / window rotation / write-back / serial readout controller.
// Define CONV_BANK_ROUTER_SAT_EN to clamp result write-back to pixel range.
module conv_bank_router
    import conv_pkg::*;
#(
    parameter int unsigned N           = 2,
    parameter int unsigned M_LEN       = 3,
    parameter int unsigned BITS_IMAGEN = BITS_IMAGEN_DEF,
    parameter int unsigned BITS_DATA   = BITS_DATA_DEF,
    parameter int unsigned NB_ADDRESS  = 10
) (
    input  logic                                      i_CLK,
    input  logic                                      i_reset,
    input  logic                                      i_load,
    input  logic                                      i_sop,
    input  logic                                      i_eop,
    input  logic [NB_ADDRESS-1:0]                     i_imglen,
    input  logic                                      i_valid,
    input  logic [BITS_IMAGEN-1:0]                    i_data,
    input  logic                                      i_rd_en,
    input  logic [NB_ADDRESS-1:0]                     i_raddr,
    input  logic [NB_ADDRESS-1:0]                     i_waddr,
    input  logic                                      i_chblk,
    input  logic                                      i_conv_valid,
    input  logic [N*BITS_DATA-1:0]                    i_conv_data,
    input  logic [nbank(N, M_LEN)*BITS_DATA-1:0]      i_memdata,
    input  logic                                      i_rd_req,
    output logic [nbank(N, M_LEN)-1:0]                o_we,
    output logic [NB_ADDRESS-1:0]                     o_waddr,
    output logic [NB_ADDRESS-1:0]                     o_raddr,
    output logic [nbank(N, M_LEN)*BITS_DATA-1:0]      o_wdata,
    output logic [N*M_LEN*BITS_IMAGEN-1:0]            o_conv_data,
    output logic                                      o_conv_valid,
    output logic [BITS_DATA-1:0]                      o_rd_data,
    output logic                                      o_rd_valid,
    output logic                                      o_done,
    output logic                                      o_err
);

    localparam int unsigned NBANK = nbank(N, M_LEN);
    localparam int unsigned BW    = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam logic [BITS_DATA-1:0] PIX_MAX = BITS_DATA'((1 << BITS_IMAGEN) - 1);

    state_t                  state;
    logic [BW-1:0]           base, lptr, ridx;
    logic [NB_ADDRESS-1:0]   laddr, imglen, ro_addr;
    logic                    drain_cnt;
    logic                    rd_v1, rd_v2, ro_v1, ro_v2, done_p1, done_p2;
    logic [BW-1:0]           base_p1, base_p2, ro_bank_p1, ro_bank_p2;

    logic [BITS_DATA-1:0]    mem_word  [NBANK];
    logic [BITS_DATA-1:0]    lane_word [N];
    logic [BITS_DATA-1:0]    wdata_arr [NBANK];
    logic [NBANK*BITS_DATA-1:0]   wdata_nxt;
    logic [NBANK*BITS_IMAGEN-1:0] mem_pix;
    logic [NBANK-1:0]        we_nxt;
    logic [NB_ADDRESS-1:0]   waddr_nxt;
    logic                    res_fire, load_fire, load_ok, collide;

    function automatic logic [BITS_DATA-1:0] wb_word(input logic [BITS_DATA-1:0] v);
`ifdef CONV_BANK_ROUTER_SAT_EN
        if (v[BITS_DATA-1]) return '0;
        if (v > PIX_MAX) return PIX_MAX;
        return v;
`else
        return v;
`endif
    endfunction

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        assign mem_word[b] = i_memdata[b*BITS_DATA +: BITS_DATA];
        assign mem_pix[b*BITS_IMAGEN +: BITS_IMAGEN] = mem_word[b][BITS_IMAGEN-1:0];
        assign wdata_nxt[b*BITS_DATA +: BITS_DATA] = wdata_arr[b];
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        assign lane_word[k] = i_conv_data[k*BITS_DATA +: BITS_DATA];
    end

    // Shared write port: result write-back owns it, a coincident load stalls.
    always_comb begin
        logic [BW-1:0] bank;
        bank      = '0;
        we_nxt    = '0;
        waddr_nxt = o_waddr;
        collide   = 1'b0;
        for (int unsigned b = 0; b < NBANK; b++) wdata_arr[b] = '0;
        res_fire  = i_conv_valid && (state == ST_RUN);
        load_fire = i_valid && ((state == ST_LOAD) || (state == ST_RUN));
        load_ok   = load_fire && !res_fire;
        if (res_fire) begin
            waddr_nxt = i_waddr;
            for (int unsigned k = 0; k < N; k++) begin
                bank            = BW'(mod_add(32'(base), k, NBANK));
                we_nxt[bank]    = 1'b1;
                wdata_arr[bank] = wb_word(lane_word[k]);
                if (load_fire && (bank == lptr)) collide = 1'b1;
            end
        end else if (load_fire) begin
            waddr_nxt       = laddr;
            we_nxt[lptr]    = 1'b1;
            wdata_arr[lptr] = BITS_DATA'(i_data);
        end
    end

    always_ff @(posedge i_CLK or posedge i_reset) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            base       <= '0;
            lptr       <= '0;
            laddr      <= '0;
            imglen     <= '0;
            ridx       <= '0;
            ro_addr    <= '0;
            drain_cnt  <= 1'b0;
            rd_v1      <= 1'b0;
            rd_v2      <= 1'b0;
            ro_v1      <= 1'b0;
            ro_v2      <= 1'b0;
            done_p1    <= 1'b0;
            done_p2    <= 1'b0;
            base_p1    <= '0;
            base_p2    <= '0;
            ro_bank_p1 <= '0;
            ro_bank_p2 <= '0;
            o_we       <= '0;
            o_waddr    <= '0;
            o_raddr    <= '0;
            o_wdata    <= '0;
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_we    <= we_nxt;
            o_waddr <= waddr_nxt;
            o_wdata <= wdata_nxt;
            if (collide) o_err <= 1'b1;

            rd_v1      <= 1'b0;
            ro_v1      <= 1'b0;
            done_p1    <= 1'b0;
            rd_v2      <= rd_v1;
            base_p2    <= base_p1;
            ro_v2      <= ro_v1;
            ro_bank_p2 <= ro_bank_p1;
            done_p2    <= done_p1;
            o_rd_valid <= ro_v2;
            o_done     <= done_p2;
            if (ro_v2) o_rd_data <= mem_word[ro_bank_p2];
            if (done_p2) o_err <= 1'b0;

            if (load_ok) begin
                if (laddr == imglen - NB_ADDRESS'(1)) begin
                    laddr <= '0;
                    lptr  <= BW'(mod_add(32'(lptr), 1, NBANK));
                end else begin
                    laddr <= laddr + NB_ADDRESS'(1);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (i_sop) begin
                        state <= ST_RUN;
                    end else if (i_load) begin
                        state  <= ST_LOAD;
                        imglen <= i_imglen;
                        lptr   <= '0;
                        laddr  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (i_sop)        state <= ST_RUN;
                    else if (!i_load) state <= ST_IDLE;
                end
                ST_RUN: begin
                    // Reads carry the pre-rotation base down the pipe.
                    if (i_rd_en) begin
                        o_raddr <= i_raddr;
                        rd_v1   <= 1'b1;
                        base_p1 <= base;
                    end
                    if (i_chblk) base <= BW'(mod_add(32'(base), N, NBANK));
                    if (i_eop) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt) begin
                        state   <= ST_READOUT;
                        ridx    <= '0;
                        ro_addr <= '0;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                ST_READOUT: begin
                    if (i_rd_req) begin
                        o_raddr    <= ro_addr;
                        ro_v1      <= 1'b1;
                        ro_bank_p1 <= BW'(mod_add(32'(base), 32'(ridx), NBANK));
                        if (ro_addr == imglen - NB_ADDRESS'(1)) begin
                            ro_addr <= '0;
                            if (ridx == BW'(N - 1)) begin
                                done_p1 <= 1'b1;
                                state   <= ST_IDLE;
                            end else begin
                                ridx <= ridx + BW'(1);
                            end
                        end else begin
                            ro_addr <= ro_addr + NB_ADDRESS'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    bank_window_mux #(
        .N           (N),
        .M_LEN       (M_LEN),
        .BITS_IMAGEN (BITS_IMAGEN),
        .NBANK       (NBANK),
        .BW          (BW)
    ) u_mux (
        .clk       (i_CLK),
        .rst       (i_reset),
        .in_valid  (rd_v2),
        .base      (base_p2),
        .mem_pix   (mem_pix),
        .win_data  (o_conv_data),
        .win_valid (o_conv_valid)
    );

endmodule

// File: tb/tb_conv_bank_router.sv
// Scoreboard bench for conv_bank_router (N=2, M_LEN=3, 4 banks, imglen=4)
// with a behavioural 1-cycle-latency bank memory model.
module tb_conv_bank_router;

    localparam int NB = 4;
    localparam int BD = 13;
    localparam int NA = 10;
`ifdef CONV_BANK_ROUTER_SAT_EN
    localparam logic [12:0] WB0 = 13'd255;
    localparam logic [12:0] WB1 = 13'd0;
`else
    localparam logic [12:0] WB0 = 13'd300;
    localparam logic [12:0] WB1 = 13'h1FFB;
`endif

    logic clk = 1'b0;
    logic i_reset, i_load, i_sop, i_eop, i_valid, i_rd_en, i_chblk, i_conv_valid, i_rd_req;
    logic [NA-1:0] i_imglen, i_raddr, i_waddr;
    logic [7:0]    i_data;
    logic [2*BD-1:0]  i_conv_data;
    logic [NB*BD-1:0] i_memdata;
    logic [NB-1:0]    o_we;
    logic [NA-1:0]    o_waddr, o_raddr;
    logic [NB*BD-1:0] o_wdata;
    logic [47:0]      o_conv_data;
    logic             o_conv_valid, o_rd_valid, o_done, o_err;
    logic [BD-1:0]    o_rd_data;

    typedef struct { logic [47:0] data; int cyc; } win_t;
    typedef struct { logic [12:0] data; int cyc; } rd_t;
    win_t win_q[$];
    rd_t  rd_q[$];

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int done_exp = -1;
    int conv_cnt = 0;
    logic [12:0] mem [NB][1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_bank_router #(
        .N(2), .M_LEN(3), .BITS_IMAGEN(8), .BITS_DATA(BD), .NB_ADDRESS(NA)
    ) dut (
        .i_CLK(clk), .i_reset(i_reset), .i_load(i_load), .i_sop(i_sop), .i_eop(i_eop),
        .i_imglen(i_imglen), .i_valid(i_valid), .i_data(i_data), .i_rd_en(i_rd_en),
        .i_raddr(i_raddr), .i_waddr(i_waddr), .i_chblk(i_chblk),
        .i_conv_valid(i_conv_valid), .i_conv_data(i_conv_data), .i_memdata(i_memdata),
        .i_rd_req(i_rd_req), .o_we(o_we), .o_waddr(o_waddr), .o_raddr(o_raddr),
        .o_wdata(o_wdata), .o_conv_data(o_conv_data), .o_conv_valid(o_conv_valid),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_done(o_done), .o_err(o_err)
    );

    // Bank memories: synchronous write, registered read.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (o_we[b]) mem[b][o_waddr] <= o_wdata[b*BD +: BD];
            i_memdata[b*BD +: BD] <= mem[b][o_raddr];
        end
    end

    function automatic logic [47:0] win(input logic [7:0] a0, a1, a2, b0, b1, b2);
        return {b2, b1, b0, a2, a1, a0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_win(input logic [47:0] d);
        win_t e;
        e.data = d;
        e.cyc  = cyc + 3;
        win_q.push_back(e);
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents output.
    always @(negedge clk) begin
        if (o_conv_valid) begin
            conv_cnt++;
            n_vec++;
            if (win_q.size() == 0) begin
                n_bad++;
                $display("FAIL window_unexpected: got %0h at cycle %0d, none expected", o_conv_data, cyc);
            end else begin
                win_t e;
                e = win_q.pop_front();
                if (o_conv_data !== e.data || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL window: got %0h at cycle %0d expected %0h at cycle %0d",
                             o_conv_data, cyc, e.data, e.cyc);
                end
            end
        end
        if (o_rd_valid) begin
            n_vec++;
            if (rd_q.size() == 0) begin
                n_bad++;
                $display("FAIL readout_unexpected: got %0d at cycle %0d, none expected", o_rd_data, cyc);
            end else begin
                rd_t e;
                e = rd_q.pop_front();
                if (o_rd_data !== e.data || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL readout: got %0d at cycle %0d expected %0d at cycle %0d",
                             o_rd_data, cyc, e.data, e.cyc);
                end
            end
        end
        if (o_done) begin
            done_cnt++;
            n_vec++;
            if (cyc != done_exp) begin
                n_bad++;
                $display("FAIL done_timing: got cycle %0d expected cycle %0d", cyc, done_exp);
            end
        end
    end

    initial begin
        logic [12:0] rd_exp [8];
        int conv_before;
        rd_exp = '{13'd77, WB0, 13'd3, 13'd4, 13'd5, WB1, 13'd7, 13'd8};
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < 1024; a++) mem[b][a] = '0;
        i_reset = 1'b1; i_load = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_valid = 1'b0;
        i_rd_en = 1'b0; i_chblk = 1'b0; i_conv_valid = 1'b0; i_rd_req = 1'b0;
        i_imglen = '0; i_raddr = '0; i_waddr = '0; i_data = '0; i_conv_data = '0;

        // Reset state
        tick(2);
        check("reset_we_waddr_raddr", {o_we, o_waddr, o_raddr}, 64'd0);
        check("reset_flags", {o_conv_valid, o_rd_valid, o_done, o_err}, 64'd0);
        i_reset = 1'b0;
        tick();
        check("reset_wdata", 64'(o_wdata), 64'd0);
        check("reset_data", {o_conv_data, o_rd_data}, 64'd0);

        // Load 16 pixels into four banks of four
        i_load = 1'b1; i_imglen = 10'd4;
        tick();
        for (int p = 1; p <= 16; p++) begin
            i_valid = 1'b1; i_data = 8'(p);
            tick();
            if (p == 1)  check("load_first", {o_we, o_waddr, o_wdata[12:0]}, {4'b0001, 10'd0, 13'd1});
            if (p == 5)  check("load_wrap",  {o_we, o_waddr, o_wdata[25:13]}, {4'b0010, 10'd0, 13'd5});
            if (p == 16) check("load_last",  {o_we, o_waddr, o_wdata[51:39]}, {4'b1000, 10'd3, 13'd16});
        end
        i_valid = 1'b0; i_sop = 1'b1;
        tick();
        i_sop = 1'b0; i_load = 1'b0;
        tick(2);
        check("bank0", {mem[0][0], mem[0][1], mem[0][2], mem[0][3]}, {13'd1, 13'd2, 13'd3, 13'd4});
        check("bank1", {mem[1][0], mem[1][1], mem[1][2], mem[1][3]}, {13'd5, 13'd6, 13'd7, 13'd8});
        check("bank2", {mem[2][0], mem[2][1], mem[2][2], mem[2][3]}, {13'd9, 13'd10, 13'd11, 13'd12});
        check("bank3", {mem[3][0], mem[3][1], mem[3][2], mem[3][3]}, {13'd13, 13'd14, 13'd15, 13'd16});

        // Window read at base 0
        i_rd_en = 1'b1; i_raddr = 10'd2;
        push_win(win(8'd3, 8'd7, 8'd11, 8'd7, 8'd11, 8'd15));
        tick();
        i_rd_en = 1'b0;
        tick(5);

        // Readout request outside READOUT must be ignored
        i_rd_req = 1'b1;
        tick();
        i_rd_req = 1'b0;
        tick(4);

        // Write-back colliding with a load aimed at bank 0
        i_conv_valid = 1'b1; i_conv_data = {13'h1FFB, 13'd300}; i_waddr = 10'd1;
        i_valid = 1'b1; i_data = 8'd99;
        tick();
        i_conv_valid = 1'b0; i_valid = 1'b0;
        check("wb_we_waddr", {o_we, o_waddr}, {4'b0011, 10'd1});
        check("wb_wdata", 64'(o_wdata[25:0]), 64'({WB1, WB0}));
        check("collision_err", 64'(o_err), 64'd1);
        tick(2);
        check("wb_mem", {mem[0][1], mem[1][1], mem[0][0]}, {WB0, WB1, 13'd1});
        i_valid = 1'b1; i_data = 8'd77;
        tick();
        i_valid = 1'b0;
        check("load_after_drop", {o_we, o_waddr, o_wdata[12:0]}, {4'b0001, 10'd0, 13'd77});
        tick(2);

        // Rotation coincident with a read: that read keeps base 0
        i_rd_en = 1'b1; i_raddr = 10'd2; i_chblk = 1'b1;
        push_win(win(8'd3, 8'd7, 8'd11, 8'd7, 8'd11, 8'd15));
        tick();
        i_chblk = 1'b0; i_raddr = 10'd3;
        push_win(win(8'd12, 8'd16, 8'd4, 8'd16, 8'd4, 8'd8));
        tick();
        i_raddr = 10'd0;
        push_win(win(8'd9, 8'd13, 8'd77, 8'd13, 8'd77, 8'd5));
        tick();
        i_rd_en = 1'b0;
        tick(5);

        // End of run with a rotation back to base 0, then readout
        i_eop = 1'b1; i_chblk = 1'b1;
        tick();
        i_eop = 1'b0; i_chblk = 1'b0;
        tick(4);
        for (int w = 0; w < 8; w++) begin
            rd_t e;
            i_rd_req = 1'b1;
            e.data = rd_exp[w];
            e.cyc  = cyc + 3;
            rd_q.push_back(e);
            if (w == 7) done_exp = cyc + 3;
            tick();
        end
        i_rd_req = 1'b0;
        tick(6);
        check("done_count", 64'(done_cnt), 64'd1);
        check("err_cleared", 64'(o_err), 64'd0);

        // Back in IDLE: readout request ignored
        i_rd_req = 1'b1;
        tick();
        i_rd_req = 1'b0;
        tick(4);

        // Reset with two reads in flight
        i_sop = 1'b1;
        tick();
        i_sop = 1'b0;
        i_rd_en = 1'b1; i_raddr = 10'd1;
        tick();
        i_raddr = 10'd2;
        tick();
        i_rd_en = 1'b0;
        #2;
        i_reset = 1'b1;
        #1;
        check("midrst_addr", {o_we, o_waddr, o_raddr}, 64'd0);
        check("midrst_data", {o_conv_data, o_rd_data}, 64'd0);
        check("midrst_flags", {o_conv_valid, o_rd_valid, o_done, o_err}, 64'd0);
        conv_before = conv_cnt;
        tick();
        i_reset = 1'b0;
        tick(6);
        check("no_conv_after_rst", 64'(conv_cnt - conv_before), 64'd0);

        check("win_queue_empty", 64'(win_q.size()), 64'd0);
        check("rd_queue_empty", 64'(rd_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_bank_router.md
# conv_bank_router

Parametrised memory control unit for the 2D convolution datapath. It owns `NBANK = N + M_LEN - 1` external column memories and handles four jobs:
- loads image rows from the control block into the banks;
- rotates the banks so that each of `N` convolutor lanes receives an `M_LEN`-row window column;
- writes lane results back over consumed rows;
- streams the results out serially for GPIO readback.

It sits between ControlBlock/FSMv2 and the bank memories. It generalises the fixed N+2 bank, 3-row arrangement to arbitrary lane count and kernel height.

## Interface
- `N`, 2, convolutor lane count (≥1)
- `M_LEN`, 3, kernel height in rows (≥2)
- `BITS_IMAGEN`, 8, pixel width fed to lanes
- `BITS_DATA`, 13, memory word / result width
- `NB_ADDRESS`, 10, bank address width
- `i_CLK  in  1  single clock`
- `i_reset  in  1  asynchronous, active-high reset`
- `i_load  in  1  level; enter/stay in LOAD from IDLE`
- `i_sop  in  1  pulse; start run (LOAD/IDLE→RUN)`
- `i_eop  in  1  pulse; end run (RUN→DRAIN)`
- `i_imglen  in  NB_ADDRESS  row length in pixels (≥1), sampled on i_load rise`
- `i_valid  in  1  pixel strobe`
- `i_data  in  BITS_IMAGEN  pixel`
- `i_rd_en  in  1  run read strobe`
- `i_raddr  in  NB_ADDRESS  run read address`
- `i_waddr  in  NB_ADDRESS  run write-back address`
- `i_chblk  in  1  pulse; advance rotation by N`
- `i_conv_valid  in  1  results valid`
- `i_conv_data  in  N*BITS_DATA  lane results, lane k at [(k+1)*BITS_DATA-1 -: BITS_DATA]`
- `i_memdata  in  NBANK*BITS_DATA  bank read data (1-cycle memory latency)`
- `i_rd_req  in  1  readout word request`
- `o_we  out  NBANK  bank write enables`
- `o_waddr  out  NB_ADDRESS  shared write address`
- `o_raddr  out  NB_ADDRESS  shared read address`
- `o_wdata  out  NBANK*BITS_DATA  bank write data`
- `o_conv_data  out  N*M_LEN*BITS_IMAGEN  lane windows, lane k row j at index k*M_LEN+j`
- `o_conv_valid  out  1  window valid`
- `o_rd_data  out  BITS_DATA  readout word`
- `o_rd_valid  out  1  readout word valid`
- `o_done  out  1  one-cycle pulse after last readout word`
- `o_err  out  1  sticky write collision flag`

## Operation
- **Reset values.** All outputs are 0. State is IDLE, `base` = 0, `lptr` = 0, `laddr` = 0.
- **States.** IDLE, LOAD, RUN, DRAIN, READOUT.
- **IDLE→LOAD:** on `i_load`. Latch `i_imglen`, clear `lptr`/`laddr`.
- **LOAD:**
  - Each `i_valid` writes `{0, i_data}` to bank `lptr` at `laddr`.
  - `laddr` increments. At `i_imglen-1` it wraps to 0 and `lptr` advances modulo NBANK.
  - `i_load` low with no `i_sop` → IDLE.
- **LOAD/IDLE→RUN:** on `i_sop`.
- **RUN reads:**
  - `i_rd_en` drives `o_raddr = i_raddr`.
  - Returned bank `(base+j) mod NBANK` maps to row j.
  - Lane k receives rows k..k+M_LEN-1, using the low BITS_IMAGEN bits.
- **Rotation:**
  - `i_chblk` sets `base ← (base+N) mod NBANK`. It applies to reads issued from the next cycle.
  - In-flight reads carry their issuing `base` down the pipeline.
- **RUN writes:**
  - Each `i_conv_valid` writes lane k to bank `(base+k) mod NBANK` at `i_waddr`, for all k in the same cycle.
  - `i_valid` in RUN keeps loading the next rows at `lptr`/`laddr`.
- **Collision:** if a load and a result hit the same bank in the same cycle, the result write wins, the load write is dropped (`laddr` does not advance) and `o_err` sets.
- **DRAIN:** entered on `i_eop`. Waits 2 cycles for in-flight reads, then → READOUT with `ridx` = 0, `raddr` = 0.
- **READOUT:**
  - Each `i_rd_req` reads bank `(base+ridx) mod NBANK` at `raddr`, then increments `raddr`.
  - At `i_imglen-1`, `raddr` wraps and `ridx` increments.
  - After lane N-1 finishes at `i_imglen-1`: `o_done` pulses, state → IDLE, `o_err` clears.
  - `i_rd_req` outside READOUT is ignored.
- Modulo arithmetic on `base`, `lptr` and `ridx` uses compare-and-subtract, never `%`.

## Timing
- **Load and result writes:** `o_we`, `o_waddr` and `o_wdata` are registered, so the write commits 1 cycle after the strobe.
- **Window latency:** `i_rd_en` at cycle t → `o_raddr` at t+1 → `i_memdata` at t+2 → `o_conv_data`/`o_conv_valid` registered at t+3.
- **Readout latency:** `i_rd_req` at t → `o_rd_valid` at t+3. Back-to-back requests are accepted every cycle.
- **Simultaneous `i_chblk` and `i_rd_en`:** the read uses the old `base`.
- **Simultaneous `i_sop` and `i_load`:** `i_sop` wins.
- **Simultaneous `i_eop` and `i_chblk`:** the rotation is applied, then DRAIN.
- **Reset asserted mid-operation:** all outputs clear asynchronously and the pipeline valids drop, so no stale `o_conv_valid` appears after release.

## Configuration
- `CONV_BANK_ROUTER_SAT_EN` defined: result write-back clamps signed `i_conv_data` to [0, 2^BITS_IMAGEN-1].
- Undefined: the raw BITS_DATA word is written unchanged.

## Structure
- Shared package `conv_pkg`:
  - state enum;
  - `NBANK` function;
  - `BITS_IMAGEN`/`BITS_DATA` defaults;
  - `mod_add` helper for pointer wrap.
- One sub-module, `bank_window_mux`: a registered NBANK-to-N×M_LEN rotation mux, keyed by the pipelined `base`.

## Test plan
- **Load:** N=2, M_LEN=3, imglen=4, 16 pixels 1..16 → banks 0..3 hold {1-4},{5-8},{9-12},{13-16}, `lptr` wraps to 0.
- **Window:** RUN with `i_raddr`=2 and `base`=0 → lane0 {3,7,11}, lane1 {7,11,15}, `o_conv_valid` 3 cycles after `i_rd_en`.
- **Rotation:** `i_chblk` on the same cycle as a read → that read uses `base` 0, the next uses `base` 2 (lane0 rows = banks 2,3,0).
- **Write-back and collision:**
  - `i_conv_valid` with lanes {300,−5} at `i_waddr`=1 → bank0[1]=255 and bank1[1]=0 with SAT_EN; raw values without it.
  - A simultaneous load aimed at bank0 is dropped and `o_err`=1.
- **Readout:** after `i_eop`, 8 `i_rd_req` → 8 words in bank/address order and `o_done` 3 cycles after the last request, back in IDLE.
- **Reset mid-RUN:** `i_reset` with 2 reads in flight → all outputs 0 immediately, no `o_conv_valid` after release.
